// File: rtl/lzss_decoder.sv
// Streaming LZSS decompressor: literal or (offset,length) tokens in, one decoded symbol per clock out.
// History window is a write-as-you-emit RAM; reads are taken relative to the write pointer.
//
// state | meaning
// IDLE  | waiting for a token
// COPY  | replaying match bytes; remaining==1 means the last byte is showing and a token may be taken
module lzss_decoder #(
    parameter int SYMBOL_LENGTH = 8,
    parameter int WINDOW_SIZE   = 4096,
    parameter int LEN_W         = SYMBOL_LENGTH,
    parameter int OFF_W         = 2 * SYMBOL_LENGTH
) (
    input  logic                       clk,
    input  logic                       rst_,
    input  logic [3*SYMBOL_LENGTH-1:0] data_in,
    input  logic                       literal,
    input  logic                       data_ready,
    output logic                       new_data_ready,
    output logic [SYMBOL_LENGTH-1:0]   data_out,
    output logic                       data_valid
);
    localparam int AW = $clog2(WINDOW_SIZE);

    typedef enum logic {IDLE, COPY} state_t;

    state_t                   state, state_nx;
    logic [AW-1:0]            wr_ptr;
    logic [OFF_W-1:0]         off_q, off_nx;
    logic [LEN_W-1:0]         remaining, remaining_nx;
    logic [SYMBOL_LENGTH-1:0] hist [WINDOW_SIZE];

    logic [LEN_W-1:0]         tok_len;
    logic [OFF_W-1:0]         tok_off;
    logic [SYMBOL_LENGTH-1:0] tok_sym;
    logic [OFF_W-1:0]         rd_off;
    logic [AW-1:0]            rd_addr;
    logic [SYMBOL_LENGTH-1:0] rd_data;
    logic                     emit_en;
    logic [SYMBOL_LENGTH-1:0] emit_sym;

    assign tok_len = data_in[3*SYMBOL_LENGTH-1 -: LEN_W];
    assign tok_off = data_in[OFF_W-1:0];
    assign tok_sym = data_in[SYMBOL_LENGTH-1:0];

    assign new_data_ready = data_ready &
                            ((state == IDLE) | ((state == COPY) & (remaining == LEN_W'(1))));

    // Offset 1 re-reads the byte emitted on the previous edge, which data_out still holds.
    assign rd_off  = new_data_ready ? tok_off : off_q;
    assign rd_addr = wr_ptr - rd_off[AW-1:0];
    assign rd_data = (rd_off == OFF_W'(1)) ? data_out : hist[rd_addr];

    always_comb begin
        state_nx     = state;
        remaining_nx = remaining;
        off_nx       = off_q;
        emit_en      = 1'b0;
        emit_sym     = rd_data;
        if (new_data_ready) begin
            state_nx     = IDLE;
            remaining_nx = '0;
            if (literal) begin
                emit_en  = 1'b1;
                emit_sym = tok_sym;
            end else if (tok_len != '0) begin
                emit_en = 1'b1;
                if (tok_len > LEN_W'(1)) begin
                    state_nx     = COPY;
                    remaining_nx = tok_len;
                    off_nx       = tok_off;
                end
            end
        end else if (data_ready && (state == COPY)) begin
            emit_en      = 1'b1;
            remaining_nx = remaining - LEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state      <= IDLE;
            remaining  <= '0;
            off_q      <= '0;
            wr_ptr     <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            state      <= state_nx;
            remaining  <= remaining_nx;
            off_q      <= off_nx;
            data_valid <= emit_en;
            if (emit_en) begin
                data_out <= emit_sym;
                wr_ptr   <= wr_ptr + AW'(1);
            end
        end
    end

    // History is deliberately not reset; writes are held off while reset is asserted.
    always_ff @(posedge clk) begin
        if (emit_en && rst_)
            hist[wr_ptr] <= emit_sym;
    end
endmodule

// File: tb/tb_lzss_decoder.sv
// Directed bench for lzss_decoder: literals, overlapping matches, stalls, reset and window wrap.
module tb_lzss_decoder;
    logic        clk = 1'b0;
    logic        rst_;
    logic [23:0] data_in;
    logic        literal;
    logic        data_ready;
    logic        new_data_ready;
    logic [7:0]  data_out;
    logic        data_valid;

    int checks   = 0;
    int failures = 0;

    lzss_decoder dut (
        .clk            (clk),
        .rst_           (rst_),
        .data_in        (data_in),
        .literal        (literal),
        .data_ready     (data_ready),
        .new_data_ready (new_data_ready),
        .data_out       (data_out),
        .data_valid     (data_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic lit(input logic [7:0] s);
        literal = 1'b1;
        data_in = {16'h0000, s};
    endtask

    task automatic mat(input logic [7:0] len, input logic [15:0] off);
        literal = 1'b0;
        data_in = {len, off};
    endtask

    task automatic exp_byte(input string tag, input logic [7:0] b);
        chk({tag, "_valid"}, data_valid, 1);
        chk({tag, "_data"}, data_out, b);
    endtask

    initial begin
        rst_       = 1'b0;
        data_ready = 1'b0;
        lit(8'h00);
        tick();
        tick();
        chk("rst_valid", data_valid, 0);
        chk("rst_data", data_out, 0);
        chk("rst_ndr_blocked", new_data_ready, 0);
        @(negedge clk);
        rst_       = 1'b1;
        data_ready = 1'b1;
        #1;
        chk("idle_ndr", new_data_ready, 1);

        // Literals a,b,c back to back (history 0..2)
        lit("a"); tick(); exp_byte("lit_a", "a"); chk("lit_a_ndr", new_data_ready, 1);
        lit("b"); tick(); exp_byte("lit_b", "b"); chk("lit_b_ndr", new_data_ready, 1);
        lit("c"); tick(); exp_byte("lit_c", "c"); chk("lit_c_ndr", new_data_ready, 1);

        // Match O=3 L=3 -> abc (history 3..5)
        mat(8'd3, 16'd3);
        tick(); exp_byte("m33_0", "a"); chk("m33_ndr0", new_data_ready, 0);
        tick(); exp_byte("m33_1", "b"); chk("m33_ndr1", new_data_ready, 0);
        tick(); exp_byte("m33_2", "c"); chk("m33_ndr_end", new_data_ready, 1);

        // 'x' then O=1 L=5 run (history 6..11)
        lit("x"); tick(); exp_byte("lit_x", "x");
        mat(8'd5, 16'd1);
        tick(); exp_byte("run_0", "x");
        for (int k = 1; k < 5; k++) begin
            tick(); exp_byte("run_k", "x");
        end
        chk("run_ndr_end", new_data_ready, 1);

        // Zero-length match consumes a token and emits nothing
        mat(8'd0, 16'd5);
        tick();
        chk("len0_valid", data_valid, 0);
        chk("len0_hold", data_out, "x");
        chk("len0_ndr", new_data_ready, 1);

        // O=9 L=4 from wr_ptr 12 -> addresses 3..6 = a,b,c,x with a 3-cycle stall
        mat(8'd4, 16'd9);
        tick(); exp_byte("stall_0", "a");
        tick(); exp_byte("stall_1", "b");
        data_ready = 1'b0;
        #1;
        chk("stall_ndr_now", new_data_ready, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_valid", data_valid, 0);
            chk("stall_ndr", new_data_ready, 0);
            chk("stall_hold", data_out, "b");
        end
        data_ready = 1'b1;
        tick(); exp_byte("stall_2", "c");
        tick(); exp_byte("stall_3", "x");
        chk("stall_ndr_end", new_data_ready, 1);

        // Reset in the middle of O=16 L=6
        mat(8'd6, 16'd16);
        tick(); exp_byte("abort_0", "a");
        tick(); exp_byte("abort_1", "b");
        lit("z");
        rst_ = 1'b0;
        #1;
        chk("abort_valid_now", data_valid, 0);
        chk("abort_data_now", data_out, 0);
        tick();
        chk("abort_valid_held", data_valid, 0);
        @(negedge clk);
        rst_ = 1'b1;
        #1;
        chk("post_rst_ndr", new_data_ready, 1);
        tick(); exp_byte("post_rst_z", "z");

        // 4100 literals (i mod 256) after 'z' wrap the window; wr_ptr ends at 5
        for (int i = 0; i < 4100; i++) begin
            lit(8'(i));
            tick();
            chk("fill_valid", data_valid, 1);
            chk("fill_data", data_out, 32'(i % 256));
        end
        mat(8'd4, 16'd4096);
        tick(); exp_byte("wrap_0", 8'd4);
        tick(); exp_byte("wrap_1", 8'd5);
        tick(); exp_byte("wrap_2", 8'd6);
        tick(); exp_byte("wrap_3", 8'd7);
        chk("wrap_ndr_end", new_data_ready, 1);

        data_ready = 1'b0;
        tick();
        chk("final_idle_valid", data_valid, 0);
        chk("final_idle_hold", data_out, 8'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
